// File: rtl/any1_branch_resolve_if.sv
// Issue-side and retire-side handshake bundle of the branch-resolution unit.
interface any1_branch_resolve_if #(
  parameter int unsigned WID  = 64,
  parameter int unsigned AWID = 32,
  parameter int unsigned TAGW = 4
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [3:0]      cond_i;
  logic [WID-1:0]  a_i;
  logic [WID-1:0]  b_i;
  logic [TAGW-1:0] tag_i;
  logic            pred_i;
  logic [AWID-1:0] tgt_i;
  logic [AWID-1:0] fall_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [TAGW-1:0] out_tag_o;
  logic            takb_o;
  logic            mispred_o;
  logic [AWID-1:0] redirect_o;
  logic [31:0]     mispred_cnt_o;

  // Unit side
  modport slave (
    input  flush_i, in_valid_i, cond_i, a_i, b_i, tag_i, pred_i, tgt_i, fall_i,
           out_ready_i,
    output in_ready_o, out_valid_o, out_tag_o, takb_o, mispred_o, redirect_o,
           mispred_cnt_o
  );

  // Issue / commit side
  modport master (
    output flush_i, in_valid_i, cond_i, a_i, b_i, tag_i, pred_i, tgt_i, fall_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, out_tag_o, takb_o, mispred_o, redirect_o,
           mispred_cnt_o
  );
endinterface

// File: rtl/any1_branch_resolve.sv
// ANY-1 branch-resolution unit: 2-stage evaluate pipeline feeding an in-order
// result FIFO, with mispredict flagging, redirect address and saturating count.
module any1_branch_resolve #(
  parameter int unsigned WID   = 64,
  parameter int unsigned AWID  = 32,
  parameter int unsigned TAGW  = 4,
  parameter int unsigned DEPTH = 4
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  any1_branch_resolve_if.slave bus
);

  localparam int unsigned BW = $clog2(WID);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  // Stage 1: registered branch inputs
  logic            r_s1_v;
  logic [3:0]      r_s1_cond;
  logic [WID-1:0]  r_s1_a;
  logic [WID-1:0]  r_s1_b;
  logic [TAGW-1:0] r_s1_tag;
  logic            r_s1_pred;
  logic [AWID-1:0] r_s1_tgt;
  logic [AWID-1:0] r_s1_fall;

  // Stage 2: evaluated result
  logic            r_s2_v;
  logic            r_s2_takb;
  logic            r_s2_mis;
  logic [AWID-1:0] r_s2_redir;
  logic [TAGW-1:0] r_s2_tag;

  // Result FIFO
  logic [TAGW-1:0] r_f_tag   [DEPTH];
  logic            r_f_takb  [DEPTH];
  logic            r_f_mis   [DEPTH];
  logic [AWID-1:0] r_f_redir [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [OW-1:0]   r_fcnt;

  logic [OW-1:0]   r_occ;
  logic            r_in_ready;
  logic [31:0]     r_mispred_cnt;

  logic            w_accept;
  logic            w_pop;
  logic            w_out_valid;
  logic            w_takb;
  logic [OW-1:0]   w_occ_nxt;
  logic [OW-1:0]   w_fcnt_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_out_valid = (r_fcnt != '0);
  assign w_accept    = bus.in_valid_i & r_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready_i;

  // Branch condition evaluation on the stage-1 operands
  always_comb begin
    w_takb = 1'b0;
    case (r_s1_cond)
      4'd0:    w_takb = (r_s1_a == r_s1_b);
      4'd1:    w_takb = (r_s1_a != r_s1_b);
      4'd2:    w_takb = ($signed(r_s1_a) <  $signed(r_s1_b));
      4'd3:    w_takb = ($signed(r_s1_a) >= $signed(r_s1_b));
      4'd4:    w_takb = (r_s1_a <  r_s1_b);
      4'd5:    w_takb = (r_s1_a >= r_s1_b);
      4'd6:    w_takb = r_s1_a[r_s1_b[BW-1:0]];
      4'd7:    w_takb = ~r_s1_a[r_s1_b[BW-1:0]];
      4'd8:    w_takb = 1'b1;
      default: w_takb = 1'b0;
    endcase
  end

  // Next occupancy (pipeline + FIFO) and next FIFO fill level
  always_comb begin
    w_occ_nxt  = r_occ;
    w_fcnt_nxt = r_fcnt;
    if (w_accept && !w_pop)      w_occ_nxt = r_occ + OW'(1);
    else if (!w_accept && w_pop) w_occ_nxt = r_occ - OW'(1);
    if (r_s2_v && !w_pop)        w_fcnt_nxt = r_fcnt + OW'(1);
    else if (!r_s2_v && w_pop)   w_fcnt_nxt = r_fcnt - OW'(1);
  end

  // Stage 1 capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_v    <= 1'b0;
      r_s1_cond <= '0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_tag  <= '0;
      r_s1_pred <= 1'b0;
      r_s1_tgt  <= '0;
      r_s1_fall <= '0;
    end else begin
      r_s1_v <= w_accept & ~bus.flush_i;
      if (w_accept) begin
        r_s1_cond <= bus.cond_i;
        r_s1_a    <= bus.a_i;
        r_s1_b    <= bus.b_i;
        r_s1_tag  <= bus.tag_i;
        r_s1_pred <= bus.pred_i;
        r_s1_tgt  <= bus.tgt_i;
        r_s1_fall <= bus.fall_i;
      end
    end
  end

  // Stage 2 capture of the resolved branch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_v     <= 1'b0;
      r_s2_takb  <= 1'b0;
      r_s2_mis   <= 1'b0;
      r_s2_redir <= '0;
      r_s2_tag   <= '0;
    end else begin
      r_s2_v <= r_s1_v & ~bus.flush_i;
      if (r_s1_v) begin
        r_s2_takb  <= w_takb;
        r_s2_mis   <= w_takb ^ r_s1_pred;
        r_s2_redir <= w_takb ? r_s1_tgt : r_s1_fall;
        r_s2_tag   <= r_s1_tag;
      end
    end
  end

  // Result FIFO storage; occupancy bound guarantees a free slot on write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_f_tag[i]   <= '0;
        r_f_takb[i]  <= 1'b0;
        r_f_mis[i]   <= 1'b0;
        r_f_redir[i] <= '0;
      end
    end else if (r_s2_v && !bus.flush_i) begin
      r_f_tag[r_tail]   <= r_s2_tag;
      r_f_takb[r_tail]  <= r_s2_takb;
      r_f_mis[r_tail]   <= r_s2_mis;
      r_f_redir[r_tail] <= r_s2_redir;
    end
  end

  // FIFO pointers, fill level, occupancy and ready
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_fcnt     <= '0;
      r_occ      <= '0;
      r_in_ready <= 1'b1;
    end else if (bus.flush_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_fcnt     <= '0;
      r_occ      <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (r_s2_v) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      r_fcnt     <= w_fcnt_nxt;
      r_occ      <= w_occ_nxt;
      r_in_ready <= (w_occ_nxt < OW'(DEPTH));
    end
  end

  // Saturating mispredict counter, bumped on each retired mispredict
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mispred_cnt <= '0;
    end else if (w_pop && r_f_mis[r_head] && !bus.flush_i && (r_mispred_cnt != '1)) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign bus.in_ready_o    = r_in_ready;
  assign bus.out_valid_o   = w_out_valid;
  assign bus.out_tag_o     = r_f_tag[r_head];
  assign bus.takb_o        = r_f_takb[r_head];
  assign bus.mispred_o     = r_f_mis[r_head] & w_out_valid;
  assign bus.redirect_o    = r_f_redir[r_head];
  assign bus.mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_any1_branch_resolve.sv
// Scoreboard bench for any1_branch_resolve: expected results are queued on
// accept and compared on each pop; occupancy and counter are modelled too.
module tb_any1_branch_resolve;

  localparam int unsigned WID   = 64;
  localparam int unsigned AWID  = 32;
  localparam int unsigned TAGW  = 4;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [TAGW-1:0] tag;
    logic            takb;
    logic            mis;
    logic [AWID-1:0] redir;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_occ    = 0;
  logic [31:0] m_cnt = '0;
  exp_t q[$];

  any1_branch_resolve_if #(.WID(WID), .AWID(AWID), .TAGW(TAGW)) bus ();

  any1_branch_resolve #(.WID(WID), .AWID(AWID), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Reference branch evaluation
  function automatic logic model_takb(input logic [3:0] c, input logic [WID-1:0] a,
                                      input logic [WID-1:0] b);
    logic [5:0] idx;
    idx = b[5:0];
    case (c)
      4'd0: return a == b;
      4'd1: return a != b;
      4'd2: return $signed(a) < $signed(b);
      4'd3: return $signed(a) >= $signed(b);
      4'd4: return a < b;
      4'd5: return a >= b;
      4'd6: return a[idx];
      4'd7: return !a[idx];
      4'd8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard monitor, sampling away from the rising edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_occ = 0;
    end else begin
      check("in_ready", 64'(bus.in_ready_o), 64'(m_occ < int'(DEPTH)));
      check("mispred_cnt", 64'(bus.mispred_cnt_o), 64'(m_cnt));
      if (!bus.out_valid_o) check("mispred_idle", 64'(bus.mispred_o), 64'd0);
      if (bus.flush_i) begin
        q.delete();
        m_occ = 0;
      end else begin
        if (bus.in_valid_i && bus.in_ready_o) begin
          e.takb  = model_takb(bus.cond_i, bus.a_i, bus.b_i);
          e.tag   = bus.tag_i;
          e.mis   = e.takb ^ bus.pred_i;
          e.redir = e.takb ? bus.tgt_i : bus.fall_i;
          q.push_back(e);
          m_occ++;
        end
        if (bus.out_valid_o && bus.out_ready_i) begin
          if (q.size() == 0) begin
            check("pop_empty", 64'(bus.out_valid_o), 64'd0);
          end else begin
            e = q.pop_front();
            check("out_tag", 64'(bus.out_tag_o), 64'(e.tag));
            check("takb", 64'(bus.takb_o), 64'(e.takb));
            check("mispred", 64'(bus.mispred_o), 64'(e.mis));
            check("redirect", 64'(bus.redirect_o), 64'(e.redir));
            m_occ--;
            if (e.mis && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
          end
        end
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] t, input logic p, input logic [31:0] tg,
                      input logic [31:0] fl);
    logic acc;
    acc = 1'b0;
    bus.cond_i = c; bus.a_i = a; bus.b_i = b; bus.tag_i = t;
    bus.pred_i = p; bus.tgt_i = tg; bus.fall_i = fl;
    bus.in_valid_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = bus.in_ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0 && !bus.out_valid_o) break;
      @(posedge clk);
      #1;
    end
    check("drain_valid", 64'(bus.out_valid_o), 64'd0);
    check("drain_queue", 64'(q.size()), 64'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t;
    logic [3:0] held_tag;
    bit done;
    rst_n = 1'b0;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    bus.cond_i = '0; bus.a_i = '0; bus.b_i = '0; bus.tag_i = '0;
    bus.pred_i = 1'b0; bus.tgt_i = '0; bus.fall_i = '0;
    cycles(3);
    check("rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_mispred", 64'(bus.mispred_o), 64'd0);
    check("rst_takb", 64'(bus.takb_o), 64'd0);
    check("rst_tag", 64'(bus.out_tag_o), 64'd0);
    check("rst_redirect", 64'(bus.redirect_o), 64'd0);
    check("rst_cnt", 64'(bus.mispred_cnt_o), 64'd0);
    rst_n = 1'b1;
    cycles(1);
    check("rst_ready", 64'(bus.in_ready_o), 64'd1);

    // Latency and first result
    bus.out_ready_i = 1'b1;
    send(4'd0, 64'h5, 64'h5, 4'd1, 1'b0, 32'h100, 32'h8);
    check("lat_e0", 64'(bus.out_valid_o), 64'd0);
    cycles(1);
    check("lat_e1", 64'(bus.out_valid_o), 64'd0);
    cycles(1);
    check("lat_e2", 64'(bus.out_valid_o), 64'd1);
    check("t1_takb", 64'(bus.takb_o), 64'd1);
    check("t1_mispred", 64'(bus.mispred_o), 64'd1);
    check("t1_redirect", 64'(bus.redirect_o), 64'h100);
    drain();

    // Signed / unsigned and bit conditions
    send(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd2, 1'b1, 32'h200, 32'h10);
    send(4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd3, 1'b1, 32'h204, 32'h14);
    send(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd4, 1'b0, 32'h208, 32'h18);
    send(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd5, 1'b0, 32'h20C, 32'h1C);
    send(4'd6, 64'h8, 64'hFFFF_FFC3, 4'd6, 1'b1, 32'h210, 32'h20);
    send(4'd7, 64'h8, 64'd3, 4'd7, 1'b0, 32'h214, 32'h24);
    send(4'd8, 64'd0, 64'd0, 4'd8, 1'b0, 32'h218, 32'h28);
    send(4'd12, 64'd0, 64'd0, 4'd9, 1'b1, 32'h21C, 32'h2C);
    send(4'd1, 64'h7, 64'h7, 4'd10, 1'b0, 32'h220, 32'h30);
    drain();

    // Backpressure: fill, verify hold and ordering
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send(4'(i % 9), 64'(i), 64'(3 - i), 4'(i), 1'(i & 1), 32'(32'h300 + i), 32'(32'h40 + i));
    cycles(2);
    check("full_ready", 64'(bus.in_ready_o), 64'd0);
    check("full_valid", 64'(bus.out_valid_o), 64'd1);
    held_tag = bus.out_tag_o;
    cycles(2);
    check("hold_tag", 64'(bus.out_tag_o), 64'(held_tag));
    check("head_tag0", 64'(bus.out_tag_o), 64'd0);
    bus.out_ready_i = 1'b1;
    send(4'd8, 64'd0, 64'd0, 4'd4, 1'b1, 32'h310, 32'h50);
    send(4'd9, 64'd0, 64'd0, 4'd5, 1'b1, 32'h314, 32'h54);
    drain();

    // Random stream with random backpressure, covers wrap and full+pop
    done = 0;
    fork
      begin
        for (int i = 0; i < 3 * int'(DEPTH) + 8; i++) begin
          logic [63:0] a, b;
          a = {$urandom, $urandom};
          b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
          t = 4'(i);
          send(4'($urandom_range(0, 15)), a, b, t, 1'($urandom_range(0, 1)),
               $urandom, $urandom);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2;
          bus.out_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready_i = 1'b1;
    drain();

    // Flush with branches in flight and a same-cycle accept
    bus.out_ready_i = 1'b0;
    send(4'd8, 64'd0, 64'd0, 4'd11, 1'b0, 32'h400, 32'h60);
    send(4'd8, 64'd0, 64'd0, 4'd12, 1'b0, 32'h404, 32'h64);
    send(4'd8, 64'd0, 64'd0, 4'd13, 1'b0, 32'h408, 32'h68);
    bus.tag_i = 4'd14; bus.in_valid_i = 1'b1; bus.flush_i = 1'b1;
    bus.out_ready_i = 1'b1;
    cycles(1);
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    check("flush_valid", 64'(bus.out_valid_o), 64'd0);
    check("flush_ready", 64'(bus.in_ready_o), 64'd1);
    check("flush_cnt", 64'(bus.mispred_cnt_o), 64'(m_cnt));
    cycles(4);
    check("flush_quiet", 64'(bus.out_valid_o), 64'd0);

    // Counter saturation
    force dut.r_mispred_cnt = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_mispred_cnt;
    send(4'd8, 64'd0, 64'd0, 4'd1, 1'b0, 32'h500, 32'h70);
    send(4'd8, 64'd0, 64'd0, 4'd2, 1'b0, 32'h504, 32'h74);
    drain();
    check("sat_cnt", 64'(bus.mispred_cnt_o), 64'hFFFF_FFFF);

    // Asynchronous reset mid-stream
    bus.out_ready_i = 1'b0;
    send(4'd8, 64'd0, 64'd0, 4'd3, 1'b1, 32'h600, 32'h80);
    send(4'd0, 64'd1, 64'd2, 4'd4, 1'b1, 32'h604, 32'h84);
    bus.in_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    m_cnt = '0;
    #1;
    check("arst_valid", 64'(bus.out_valid_o), 64'd0);
    check("arst_mispred", 64'(bus.mispred_o), 64'd0);
    check("arst_takb", 64'(bus.takb_o), 64'd0);
    check("arst_tag", 64'(bus.out_tag_o), 64'd0);
    check("arst_redirect", 64'(bus.redirect_o), 64'd0);
    check("arst_cnt", 64'(bus.mispred_cnt_o), 64'd0);
    bus.in_valid_i = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    check("post_rst_ready", 64'(bus.in_ready_o), 64'd1);
    check("post_rst_valid", 64'(bus.out_valid_o), 64'd0);
    bus.out_ready_i = 1'b1;
    send(4'd1, 64'd1, 64'd2, 4'd7, 1'b0, 32'h700, 32'h90);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
